// File: rtl/sdram_ch_arbiter.sv
// Two-requester arbiter for one byte-wide SDRAM channel: sequences strobe/settle/busy/ack
// for each access and inserts periodic refresh pulses between accesses.
module sdram_ch_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int REFRESH_INT = 1024,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_busy,
  output logic              mem_refresh
);

  localparam int RW = $clog2(REFRESH_INT);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE_W, S_WAIT_BUSY, S_DONE, S_REFRESH
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_ref_cnt;
  logic            r_ref_pend;
  logic            r_last_b;
  logic            r_gnt_b;
  logic [SW-1:0]   r_settle;
  logic [TW-1:0]   r_tmo;
  logic            w_wrap;
  logic            w_pick_b;
  logic            w_we;

  assign w_wrap   = (r_ref_cnt == RW'(REFRESH_INT - 1));
  // B wins when alone, or when both request and A was served last
  assign w_pick_b = b_req && (!a_req || !r_last_b);
  assign w_we     = w_pick_b ? b_we : a_we;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_ref_cnt <= '0;
    else if (w_wrap) r_ref_cnt <= '0;
    else r_ref_cnt <= r_ref_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ref_pend  <= 1'b0;
      r_last_b    <= 1'b1;
      r_gnt_b     <= 1'b0;
      r_settle    <= '0;
      r_tmo       <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_din     <= '0;
      mem_refresh <= 1'b0;
    end else begin
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      mem_refresh <= 1'b0;
      if (w_wrap) r_ref_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_ref_pend) begin
            mem_refresh <= 1'b1;
            r_state     <= S_REFRESH;
          end else if (a_req || b_req) begin
            r_gnt_b  <= w_pick_b;
            r_last_b <= w_pick_b;
            mem_addr <= w_pick_b ? b_addr : a_addr;
            mem_din  <= w_pick_b ? b_wdata : a_wdata;
            mem_wr   <= w_we;
            mem_rd   <= !w_we;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_settle <= '0;
          r_state  <= S_SETTLE_W;
        end
        S_SETTLE_W: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_tmo   <= '0;
            r_state <= S_WAIT_BUSY;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (!mem_busy) begin
            if (mem_rd) rdata <= mem_dout;
            a_ack   <= !r_gnt_b;
            b_ack   <= r_gnt_b;
            r_state <= S_DONE;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            err     <= 1'b1;
            a_ack   <= !r_gnt_b;
            b_ack   <= r_gnt_b;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          mem_wr  <= 1'b0;
          mem_rd  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_REFRESH: begin
          // a wrap landing on this edge re-arms the request instead of being lost
          if (!w_wrap) r_ref_pend <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
